// File: rtl/intr_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module : intr_req_ctrl
// Desc   : Responder side of the fetch-stage intr/int_clr handshake. Captures
//          rising edges of an asynchronous interrupt pin, waits for a safe
//          pipeline point, raises intr, and tracks the service routine.
// Rev    : 1.0  initial release
// ============================================================================
module intr_req_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int SAFE_CYCLES = 1,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic stall_in,
  input  logic fetch2_busy,
  input  logic branch_pending,
  input  logic int_clr,
  input  logic rti_retire,
  input  logic ovr_clr,
  output logic intr,
  output logic int_active,
  output logic int_pending,
  output logic irq_overrun,
  output logic ack_timeout_err
);

  localparam logic [2:0] c_safe_last = 3'(SAFE_CYCLES - 1);
  localparam logic [3:0] c_ack_last  = 4'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_ASSERT  = 2'd2,
    S_ISR     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_edge;
  logic                   w_safe;

  logic [2:0] r_safe_cnt;
  logic [2:0] w_safe_cnt_nxt;
  logic [3:0] r_to_cnt;
  logic [3:0] w_to_cnt_nxt;
  logic       r_deferred;
  logic       w_deferred_nxt;
  logic       r_overrun;
  logic       w_overrun_nxt;
  logic       r_to_err;
  logic       w_to_err_nxt;
  logic       w_ovr_evt;

  logic r_intr;
  logic r_active;
  logic r_pending;

  // Chain resets to 0, so a pin already high at release yields one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_safe = ~stall_in & ~fetch2_busy & ~branch_pending;

  always_comb begin
    w_state_nxt    = r_state;
    w_safe_cnt_nxt = '0;
    w_to_cnt_nxt   = '0;
    w_deferred_nxt = r_deferred;
    w_overrun_nxt  = r_overrun;
    w_to_err_nxt   = r_to_err;
    w_ovr_evt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_edge) w_state_nxt = S_PENDING;
      end

      S_PENDING: begin
        if (w_safe) begin
          if (r_safe_cnt >= c_safe_last) begin
            w_state_nxt = S_ASSERT;
          end else begin
            w_safe_cnt_nxt = (r_safe_cnt == 3'd7) ? r_safe_cnt : r_safe_cnt + 3'd1;
          end
        end
      end

      // Acknowledge beats a timeout landing on the same edge.
      S_ASSERT: begin
        if (int_clr) begin
          w_state_nxt    = S_ISR;
          w_deferred_nxt = 1'b0;
        end else if (r_to_cnt == c_ack_last) begin
          w_state_nxt  = S_PENDING;
          w_to_err_nxt = 1'b1;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 4'd1;
        end
      end

      S_ISR: begin
        if (w_edge) begin
          w_deferred_nxt = 1'b1;
          if (r_deferred) w_ovr_evt = 1'b1;
        end
        if (rti_retire) begin
          w_state_nxt    = (r_deferred | w_edge) ? S_PENDING : S_IDLE;
          w_deferred_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_ovr_evt) begin
      w_overrun_nxt = 1'b1;
    end else if (ovr_clr) begin
      w_overrun_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_safe_cnt <= '0;
      r_to_cnt   <= '0;
      r_deferred <= 1'b0;
      r_overrun  <= 1'b0;
      r_to_err   <= 1'b0;
      r_intr     <= 1'b0;
      r_active   <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_safe_cnt <= w_safe_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_deferred <= w_deferred_nxt;
      r_overrun  <= w_overrun_nxt;
      r_to_err   <= w_to_err_nxt;
      r_intr     <= (w_state_nxt == S_ASSERT);
      r_active   <= (w_state_nxt == S_ISR);
      r_pending  <= (w_state_nxt == S_PENDING);
    end
  end

  assign intr            = r_intr;
  assign int_active      = r_active;
  assign int_pending     = r_pending;
  assign irq_overrun     = r_overrun;
  assign ack_timeout_err = r_to_err;

endmodule
`default_nettype wire

// File: tb/tb_intr_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_intr_req_ctrl
// Desc   : Self-checking bench for intr_req_ctrl (SAFE_CYCLES 1 and 3 copies)
// Rev    : 1.0  initial release
// ============================================================================
module tb_intr_req_ctrl;

  localparam int S   = 2;
  localparam int ACK = 8;
  localparam int M_IDLE = 0, M_PEND = 1, M_ASRT = 2, M_ISR = 3;

  logic clk = 1'b0;
  logic reset, irq_in, stall_in, fetch2_busy, branch_pending;
  logic int_clr, rti_retire, ovr_clr;
  logic intr_a, act_a, pend_a, ovr_a, toe_a;
  logic intr_b, act_b, pend_b, ovr_b, toe_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  intr_req_ctrl #(.SYNC_STAGES(S), .SAFE_CYCLES(1), .ACK_TIMEOUT(ACK)) dut_a (
    .clk(clk), .reset(reset), .irq_in(irq_in), .stall_in(stall_in),
    .fetch2_busy(fetch2_busy), .branch_pending(branch_pending),
    .int_clr(int_clr), .rti_retire(rti_retire), .ovr_clr(ovr_clr),
    .intr(intr_a), .int_active(act_a), .int_pending(pend_a),
    .irq_overrun(ovr_a), .ack_timeout_err(toe_a));

  intr_req_ctrl #(.SYNC_STAGES(S), .SAFE_CYCLES(3), .ACK_TIMEOUT(ACK)) dut_b (
    .clk(clk), .reset(reset), .irq_in(irq_in), .stall_in(stall_in),
    .fetch2_busy(fetch2_busy), .branch_pending(branch_pending),
    .int_clr(int_clr), .rti_retire(rti_retire), .ovr_clr(ovr_clr),
    .intr(intr_b), .int_active(act_b), .int_pending(pend_b),
    .irq_overrun(ovr_b), .ack_timeout_err(toe_b));

  // Reference model: pin history queue plus a request lifecycle per copy.
  bit samp[$];
  int m_mode[2];
  int m_run[2];
  int m_age[2];
  bit m_def[2], m_ovr[2], m_toe[2];
  int need[2] = '{1, 3};

  function automatic void model_reset();
    samp.delete();
    for (int k = 0; k <= S; k++) samp.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_run[i] = 0; m_age[i] = 0;
      m_def[i] = 0; m_ovr[i] = 0; m_toe[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit e, safe, drop;
    e    = samp[S-1] & ~samp[S];
    safe = !(stall_in || fetch2_busy || branch_pending);
    for (int i = 0; i < 2; i++) begin
      drop = 0;
      case (m_mode[i])
        M_IDLE: if (e) begin m_mode[i] = M_PEND; m_run[i] = 0; end
        M_PEND: begin
          if (safe) begin
            m_run[i]++;
            if (m_run[i] >= need[i]) begin m_mode[i] = M_ASRT; m_age[i] = 0; end
          end else m_run[i] = 0;
        end
        M_ASRT: begin
          if (int_clr) begin m_mode[i] = M_ISR; m_def[i] = 0; end
          else begin
            m_age[i]++;
            if (m_age[i] >= ACK) begin m_mode[i] = M_PEND; m_run[i] = 0; m_toe[i] = 1; end
          end
        end
        default: begin
          if (e && m_def[i]) drop = 1;
          if (e) m_def[i] = 1;
          if (rti_retire) begin
            m_mode[i] = m_def[i] ? M_PEND : M_IDLE;
            m_def[i] = 0; m_run[i] = 0;
          end
        end
      endcase
      if (drop) m_ovr[i] = 1;
      else if (ovr_clr) m_ovr[i] = 0;
    end
    samp.push_front(irq_in);
    void'(samp.pop_back());
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d t=%0t: got %b expected %b", nm, cyc, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic a_intr, input logic a_act,
                          input logic a_pend, input logic a_ovr, input logic a_toe);
    chk($sformatf("model%0d.intr", i), a_intr, m_mode[i] == M_ASRT);
    chk($sformatf("model%0d.int_active", i), a_act, m_mode[i] == M_ISR);
    chk($sformatf("model%0d.int_pending", i), a_pend, m_mode[i] == M_PEND);
    chk($sformatf("model%0d.irq_overrun", i), a_ovr, m_ovr[i]);
    chk($sformatf("model%0d.ack_timeout_err", i), a_toe, m_toe[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
    cyc++;
    cmp_inst(0, intr_a, act_a, pend_a, ovr_a, toe_a);
    cmp_inst(1, intr_b, act_b, pend_b, ovr_b, toe_b);
  endtask

  task automatic clear_inputs();
    stall_in = 0; fetch2_busy = 0; branch_pending = 0;
    int_clr = 0; rti_retire = 0; ovr_clr = 0;
  endtask

  // Asserts reset mid-cycle, checks outputs drop before any edge, then releases.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst.intr", intr_a | intr_b, 1'b0);
    chk("async_rst.int_active", act_a | act_b, 1'b0);
    chk("async_rst.int_pending", pend_a | pend_b, 1'b0);
    chk("async_rst.irq_overrun", ovr_a | ovr_b, 1'b0);
    chk("async_rst.ack_timeout_err", toe_a | toe_b, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    cyc = 0;
  endtask

  // Timeout, ISR with two pin pulses, deferred replay and overrun clear.
  task automatic seq_timeout_isr(input int last);
    for (int e = 1; e <= last; e++) begin
      irq_in     = (e >= 10 && e <= 23) || e == 26 || e == 27 || e == 30 || e == 31;
      int_clr    = (e == 23) || (e == 37);
      rti_retire = (e == 34) || (e == 39);
      ovr_clr    = (e == 36);
      tick();
      if (e == 20) begin chk("t3.intr_before_to", intr_a, 1'b1); chk("t3.err_before_to", toe_a, 1'b0); end
      if (e == 21) begin
        chk("t3.intr_at_to", intr_a, 1'b0);
        chk("t3.pending_at_to", pend_a, 1'b1);
        chk("t3.err_at_to", toe_a, 1'b1);
      end
      if (e == 22) chk("t3.reassert", intr_a, 1'b1);
      if (e == 23) begin
        chk("t3.isr_a", act_a, 1'b1);
        chk("t3.intr_off", intr_a, 1'b0);
        chk("t3.clr_wins_isr_b", act_b, 1'b1);
        chk("t3.clr_wins_no_err_b", toe_b, 1'b0);
      end
      if (e == 31) chk("t4.no_ovr_yet", ovr_a, 1'b0);
      if (e == 32) begin chk("t4.ovr_a", ovr_a, 1'b1); chk("t4.ovr_b", ovr_b, 1'b1); end
      if (e == 34) begin chk("t4.rti_pending", pend_a, 1'b1); chk("t4.rti_not_active", act_a, 1'b0); end
      if (e == 35) chk("t4.reassert", intr_a, 1'b1);
      if (e == 36) chk("t4.ovr_clr", ovr_a, 1'b0);
      if (e == 39) begin
        chk("t4.idle_act", act_a, 1'b0);
        chk("t4.idle_pend", pend_a, 1'b0);
        chk("t4.idle_intr", intr_a, 1'b0);
      end
    end
    clear_inputs();
  endtask

  typedef struct {
    logic irq;
    logic clr;
    logic rti;
    logic x_intr;
    logic x_act;
    logic x_pend;
  } vec_t;

  vec_t tbl[21];

  initial begin
    for (int e = 1; e <= 21; e++) begin
      tbl[e-1].irq    = (e >= 10);
      tbl[e-1].clr    = (e == 15);
      tbl[e-1].rti    = (e == 20);
      tbl[e-1].x_intr = (e == 13 || e == 14);
      tbl[e-1].x_act  = (e >= 15 && e < 20);
      tbl[e-1].x_pend = (e == 12);
    end

    reset = 1'b0; irq_in = 1'b0;
    clear_inputs();
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    cyc = 0;

    // Basic handshake from the vector table.
    for (int r = 0; r < 21; r++) begin
      irq_in = tbl[r].irq; int_clr = tbl[r].clr; rti_retire = tbl[r].rti;
      tick();
      chk($sformatf("t1[%0d].intr", r + 1), intr_a, tbl[r].x_intr);
      chk($sformatf("t1[%0d].int_active", r + 1), act_a, tbl[r].x_act);
      chk($sformatf("t1[%0d].int_pending", r + 1), pend_a, tbl[r].x_pend);
      chk($sformatf("t1[%0d].irq_overrun", r + 1), ovr_a, 1'b0);
      chk($sformatf("t1[%0d].ack_timeout_err", r + 1), toe_a, 1'b0);
    end
    clear_inputs();

    // Stall delays assertion; SAFE_CYCLES=3 copy needs three safe cycles.
    irq_in = 1'b0;
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      irq_in     = (e >= 10);
      stall_in   = (e >= 12 && e <= 17);
      int_clr    = (e == 21);
      rti_retire = (e == 23);
      tick();
      if (e == 17) begin chk("t2.held_low", intr_a, 1'b0); chk("t2.still_pending", pend_a, 1'b1); end
      if (e == 18) chk("t2.first_safe", intr_a, 1'b1);
      if (e == 19) chk("t2.b_held_low", intr_b, 1'b0);
      if (e == 20) chk("t2.b_third_safe", intr_b, 1'b1);
      if (e == 21) begin chk("t2.isr_a", act_a, 1'b1); chk("t2.isr_b", act_b, 1'b1); end
      if (e == 23) begin chk("t2.idle_a", act_a, 1'b0); chk("t2.idle_b", act_b, 1'b0); end
    end
    clear_inputs();

    irq_in = 1'b0;
    do_reset();
    seq_timeout_isr(40);

    // Pin held high across reset release gives exactly one request.
    irq_in = 1'b1;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      int_clr    = (e == 6 || e == 7);
      rti_retire = (e == 8);
      tick();
      if (e == 1) chk("t5.not_yet", pend_a, 1'b0);
      if (e == 3) chk("t5.pending", pend_a, 1'b1);
      if (e == 4) chk("t5.intr", intr_a, 1'b1);
      if (e == 30) begin
        chk("t5.single_a", pend_a | intr_a | act_a, 1'b0);
        chk("t5.single_b", pend_b | intr_b | act_b, 1'b0);
      end
    end
    clear_inputs();

    // Reset while in ASSERT, then while in ISR with deferred and sticky flags set.
    irq_in = 1'b0;
    do_reset();
    for (int e = 1; e <= 13; e++) begin
      irq_in = (e >= 10);
      tick();
    end
    chk("t6.in_assert", intr_a, 1'b1);
    irq_in = 1'b0;
    do_reset();
    seq_timeout_isr(33);
    chk("t6.pre_ovr", ovr_a, 1'b1);
    chk("t6.pre_err", toe_a, 1'b1);
    chk("t6.pre_isr", act_a, 1'b1);
    irq_in = 1'b0;
    do_reset();
    for (int e = 1; e <= 20; e++) tick();
    chk("t6.no_req_a", pend_a | intr_a | act_a, 1'b0);
    chk("t6.no_req_b", pend_b | intr_b | act_b, 1'b0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) irq_in = ~irq_in;
      stall_in       = ($urandom_range(0, 4) == 0);
      fetch2_busy    = ($urandom_range(0, 7) == 0);
      branch_pending = ($urandom_range(0, 7) == 0);
      int_clr        = ($urandom_range(0, 3) == 0);
      rti_retire     = ($urandom_range(0, 7) == 0);
      ovr_clr        = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
